// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave backed by a preloadable 64-bit word store.
// Define AXI_RD_WRAP_EN to support WRAP bursts; otherwise they return SLVERR.
module axi_rd_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   ARID,
    input  logic [63:0]                  ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [3:0]                   RID,
    output logic [63:0]                  RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
    input  logic [63:0]                  ld_data
);

    localparam int unsigned IW        = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    logic [63:0] mem [MEM_WORDS];

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [7:0]  beat;
    logic [7:0]  len;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err_stick;

    logic [63:0] nxt_addr;
    logic [63:0] ld_a;
    logic        ld_e;
    logic [63:0] ld_d;

    function automatic logic addr_err(
        input logic [63:0] a,
        input logic [2:0]  sz,
        input logic [1:0]  bu
    );
        logic [63:0] off;
        logic        bad_bu;
        off = a - BASE_ADDR;
`ifdef AXI_RD_WRAP_EN
        bad_bu = (bu == 2'b11);
`else
        bad_bu = (bu == 2'b10) || (bu == 2'b11);
`endif
        return (a < BASE_ADDR) || (off >= MEM_BYTES) ||
               (sz > 3'd3) || bad_bu;
    endfunction

    function automatic logic [IW-1:0] widx(input logic [63:0] a);
        return IW'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [63:0] step(
        input logic [63:0] a,
        input logic [2:0]  sz,
        input logic [7:0]  ln,
        input logic [1:0]  bu
    );
        logic [63:0] inc;
        logic [63:0] mask;
        logic [63:0] res;
        inc  = 64'd1 << sz;
        mask = ((64'(ln) + 64'd1) << sz) - 64'd1;
        case (bu)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | ((a + inc) & mask);
            default: res = a + inc;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Address and response of the beat to be registered at this edge.
    // Once a beat errs, the rest of the burst stays in error.
    always_comb begin
        nxt_addr = step(addr, size, len, burst);
        ld_a     = nxt_addr;
        ld_e     = 1'b0;
        if (state == IDLE) begin
            ld_a = ARADDR;
            ld_e = addr_err(ARADDR, ARSIZE, ARBURST);
        end else begin
            if (state == WAIT) begin
                ld_a = addr;
            end
            ld_e = err_stick | addr_err(ld_a, size, burst);
        end
        ld_d = ld_e ? 64'd0 : mem[widx(ld_a)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RID       <= 4'd0;
            RDATA     <= 64'd0;
            RRESP     <= 2'b00;
            lat_cnt   <= 4'd0;
            beat      <= 8'd0;
            len       <= 8'd0;
            addr      <= 64'd0;
            size      <= 3'd0;
            burst     <= 2'b00;
            err_stick <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ARREADY && ARVALID) begin
                        ARREADY   <= 1'b0;
                        RID       <= ARID;
                        addr      <= ARADDR;
                        len       <= ARLEN;
                        size      <= ARSIZE;
                        burst     <= ARBURST;
                        beat      <= 8'd0;
                        err_stick <= 1'b0;
                        if (RD_LAT == 0) begin
                            state     <= BURST;
                            RVALID    <= 1'b1;
                            RLAST     <= (ARLEN == 8'd0);
                            RDATA     <= ld_d;
                            RRESP     <= ld_e ? 2'b10 : 2'b00;
                            err_stick <= ld_e;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 4'(RD_LAT);
                        end
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        state     <= BURST;
                        lat_cnt   <= 4'd0;
                        RVALID    <= 1'b1;
                        RLAST     <= (len == 8'd0);
                        RDATA     <= ld_d;
                        RRESP     <= ld_e ? 2'b10 : 2'b00;
                        err_stick <= ld_e;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            state   <= IDLE;
                            ARREADY <= 1'b1;
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RDATA   <= 64'd0;
                            RRESP   <= 2'b00;
                            beat    <= 8'd0;
                        end else begin
                            beat      <= beat + 8'd1;
                            addr      <= nxt_addr;
                            RLAST     <= ((beat + 8'd1) == len);
                            RDATA     <= ld_d;
                            RRESP     <= ld_e ? 2'b10 : 2'b00;
                            err_stick <= ld_e;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed self-checking bench for axi_rd_slave (RD_LAT=3).
// Expectations for the WRAP case follow AXI_RD_WRAP_EN.
module tb_axi_rd_slave;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [63:0] ld_data;

    int checks;
    int failures;
    logic [63:0] exp_d [8];

    axi_rd_slave #(
        .MEM_WORDS(1024),
        .BASE_ADDR(64'h8000_0000),
        .RD_LAT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ARID(ARID),
        .ARADDR(ARADDR),
        .ARLEN(ARLEN),
        .ARSIZE(ARSIZE),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RID(RID),
        .RDATA(RDATA),
        .RRESP(RRESP),
        .RLAST(RLAST),
        .RVALID(RVALID),
        .RREADY(RREADY),
        .ld_en(ld_en),
        .ld_idx(ld_idx),
        .ld_data(ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
        exp_d[0] = a;
        exp_d[1] = b;
        exp_d[2] = c;
        exp_d[3] = d;
    endtask

    task automatic ar(input logic [3:0] id, input logic [63:0] a,
                      input logic [7:0] ln, input logic [2:0] sz,
                      input logic [1:0] bu);
        chk("ar_ready", 64'(ARREADY), 64'd1);
        ARID    = id;
        ARADDR  = a;
        ARLEN   = ln;
        ARSIZE  = sz;
        ARBURST = bu;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic run_burst(input string tag, input int n,
                             input logic [3:0] id, input logic [1:0] resp,
                             input bit toggle, input int exp_wait);
        int cyc;
        int got;
        int k;
        bit rr;
        cyc = 0;
        got = 0;
        k   = 0;
        while (!RVALID && cyc < 40) begin
            chk({tag, "_ardy_wait"}, 64'(ARREADY), 64'd0);
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_wait));
        while (got < n && k < 200) begin
            rr = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            chk({tag, "_rvalid"}, 64'(RVALID), 64'd1);
            chk({tag, "_rid"}, 64'(RID), 64'(id));
            chk({tag, "_rdata"}, RDATA, exp_d[got[2:0]]);
            chk({tag, "_rresp"}, 64'(RRESP), 64'(resp));
            chk({tag, "_rlast"}, 64'(RLAST), 64'(got == n - 1));
            chk({tag, "_ardy_busy"}, 64'(ARREADY), 64'd0);
            RREADY = rr;
            tick();
            if (rr) got++;
            k++;
        end
        RREADY = 1'b0;
        chk({tag, "_beats"}, 64'(got), 64'(n));
        chk({tag, "_end_rvalid"}, 64'(RVALID), 64'd0);
        chk({tag, "_end_ardy"}, 64'(ARREADY), 64'd1);
    endtask

    initial begin
        int cyc;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ARID     = 4'd0;
        ARADDR   = 64'd0;
        ARLEN    = 8'd0;
        ARSIZE   = 3'd0;
        ARBURST  = 2'b00;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        ld_en    = 1'b0;
        ld_idx   = 10'd0;
        ld_data  = 64'd0;
        repeat (3) tick();

        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rid", 64'(RID), 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);

        rst = 1'b0;
        tick();
        chk("ardy_after_rst", 64'(ARREADY), 64'd1);

        for (int i = 0; i < 8; i++) begin
            ld_en   = 1'b1;
            ld_idx  = 10'(i);
            ld_data = 64'(11 * (i + 1));
            tick();
        end
        ld_en = 1'b0;

        set_exp(64'd11, 64'd22, 64'd33, 64'd44);
        ar(4'd5, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
        run_burst("incr", 4, 4'd5, 2'b00, 1'b0, 3);

        ar(4'd5, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
        run_burst("incr_bp", 4, 4'd5, 2'b00, 1'b1, 3);

        exp_d[0] = 64'd22;
        ar(4'd3, 64'h8000_0008, 8'd0, 3'd3, 2'b01);
        run_burst("single", 1, 4'd3, 2'b00, 1'b0, 3);

        set_exp(64'd0, 64'd0, 64'd0, 64'd0);
        ar(4'd9, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b01);
        run_burst("oor", 2, 4'd9, 2'b10, 1'b0, 3);

`ifdef AXI_RD_WRAP_EN
        set_exp(64'd33, 64'd44, 64'd11, 64'd22);
        ar(4'd1, 64'h8000_0010, 8'd3, 3'd3, 2'b10);
        run_burst("wrap", 4, 4'd1, 2'b00, 1'b0, 3);
`else
        set_exp(64'd0, 64'd0, 64'd0, 64'd0);
        ar(4'd1, 64'h8000_0010, 8'd3, 3'd3, 2'b10);
        run_burst("wrap_off", 4, 4'd1, 2'b10, 1'b0, 3);
`endif

        set_exp(64'd44, 64'd44, 64'd44, 64'd0);
        ar(4'd7, 64'h8000_0018, 8'd2, 3'd3, 2'b00);
        run_burst("fixed", 3, 4'd7, 2'b00, 1'b1, 3);

        set_exp(64'd11, 64'd11, 64'd22, 64'd22);
        ar(4'd8, 64'h8000_0000, 8'd3, 3'd2, 2'b01);
        run_burst("narrow", 4, 4'd8, 2'b00, 1'b0, 3);

        set_exp(64'd0, 64'd0, 64'd0, 64'd0);
        ar(4'd10, 64'h8000_0000, 8'd1, 3'd4, 2'b01);
        run_burst("bigsize", 2, 4'd10, 2'b10, 1'b0, 3);

        ar(4'd11, 64'h8000_0000, 8'd0, 3'd3, 2'b11);
        run_burst("rsvd_burst", 1, 4'd11, 2'b10, 1'b0, 3);

        // Backdoor write lands on the same edge as the first beat fetch.
        exp_d[0] = 64'd55;
        ar(4'd6, 64'h8000_0020, 8'd0, 3'd3, 2'b01);
        tick();
        tick();
        ld_en   = 1'b1;
        ld_idx  = 10'd4;
        ld_data = 64'd99;
        tick();
        ld_en = 1'b0;
        run_burst("ld_old", 1, 4'd6, 2'b00, 1'b0, 0);
        exp_d[0] = 64'd99;
        ar(4'd6, 64'h8000_0020, 8'd0, 3'd3, 2'b01);
        run_burst("ld_new", 1, 4'd6, 2'b00, 1'b0, 3);

        ar(4'd2, 64'h8000_0000, 8'd7, 3'd3, 2'b01);
        cyc = 0;
        while (!RVALID && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("mid_rst_lat", 64'(cyc), 64'd3);
        chk("mid_rst_b0", RDATA, 64'd11);
        RREADY = 1'b1;
        tick();
        chk("mid_rst_b1_valid", 64'(RVALID), 64'd1);
        chk("mid_rst_b1_data", RDATA, 64'd22);
        rst = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
        chk("mid_rst_ardy", 64'(ARREADY), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_ardy_up", 64'(ARREADY), 64'd1);
        chk("mid_rst_no_beat", 64'(RVALID), 64'd0);

        set_exp(64'd11, 64'd22, 64'd33, 64'd0);
        ar(4'd4, 64'h8000_0000, 8'd2, 3'd3, 2'b01);
        run_burst("post_rst", 3, 4'd4, 2'b00, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
